multibyte_add_ctrl: RTL and testbench

MULTIBYTE_ADD_CTRL -- requirements
Module: multibyte_add_ctrl

---
 rtl/multibyte_add_ctrl.sv | 66 ++++++
 tb/tb_multibyte_add_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multibyte_add_ctrl.sv
// multibyte_add_ctrl: runs add/subtract of NBYTES-byte operands byte-serially through an external 8-bit adder
module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                c_in,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum_out,
  output logic                c_out
);
  localparam int W  = 8*NBYTES;
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r, res;
  logic op_r, carry, cout_r, last;
  logic [IW-1:0] idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    last    = idx == IW'(NBYTES-1);
    state_n = state == IDLE ? (start ? LOAD : IDLE) :
              state == LOAD ? RUN :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    add_a   = state == RUN ? a_r[8*idx +: 8] : 8'h00;
    add_b   = state == RUN ? b_r[8*idx +: 8] ^ {8{op_r}} : 8'h00;
    add_cin = state == RUN && carry;
    busy    = state == LOAD || state == RUN;
    done    = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      res    <= '0;
      op_r   <= 1'b0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      idx    <= '0;
    end else if (state == IDLE && start) begin
      a_r   <= a_in;
      b_r   <= b_in;
      op_r  <= op;
      carry <= op | c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      res[8*idx +: 8] <= add_sum;
      carry           <= add_cout;
      cout_r          <= last ? add_cout : cout_r;
      idx             <= last ? idx : idx + IW'(1);
    end
  assign sum_out = res;
  assign c_out   = cout_r;
endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// tb_multibyte_add_ctrl: directed vectors and multi-cycle corner cases for multibyte_add_ctrl
module tb_multibyte_add_ctrl;
  logic clk, rst_n, start, op, c_in, add_cin, add_cout, busy, done, c_out;
  logic [31:0] a_in, b_in, sum_out;
  logic [7:0] add_a, add_b, add_sum;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;
  vec_t v[9];
  multibyte_add_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .sum_out(sum_out), .c_out(c_out)
  );
  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input bit poke, output int lat, output int dones, output logic [31:0] s,
                        output logic c, output logic [31:0] s_end, output bit cin_all, output bit busy_load);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = op_i; a_in = a; b_in = b; c_in = cin;
    @(posedge clk); #1;
    start = 1'b0; busy_load = busy && !done && add_a == 8'h00 && !add_cin;
    a_in = ~a; b_in = $urandom; c_in = ~cin; op = ~op_i;
    lat = -1; dones = 0; cin_all = 1'b1; s = '0; c = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (poke && i == 2) begin start = 1'b1; a_in = 32'h11111111; end
      if (poke && i == 3) start = 1'b0;
      if (i <= 4 && !add_cin) cin_all = 1'b0;
      if (done) begin
        dones++;
        if (lat < 0) begin lat = i; s = sum_out; c = c_out; end
      end
    end
    s_end = sum_out;
  endtask
  initial begin
    int lat, dones, d;
    logic [31:0] s, s_end;
    logic c;
    bit cin_all, busy_load;
    logic [31:0] ba[3], bb[3], bs[3];
    logic bc[3];
    v[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    v[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    v[2] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0};
    v[3] = '{1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1};
    v[4] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    v[5] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    v[6] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1};
    v[7] = '{1'b0, 32'hDEADBEEF, 32'h01010101, 1'b1, 32'hDFAEBFF1, 1'b0};
    v[8] = '{1'b1, 32'h00000100, 32'h00000001, 1'b1, 32'h000000FF, 1'b1};
    ba = '{32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFF};
    bb = '{32'h00000002, 32'h00000001, 32'hFFFFFFFF};
    bs = '{32'h00000003, 32'h80000000, 32'hFFFFFFFE};
    bc = '{1'b0, 1'b0, 1'b1};
    rst_n = 1'b1; start = 1'b0; op = 1'b0; c_in = 1'b0; a_in = '0; b_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", c_out, 0);
    check("rst_adder", {add_a, add_b, add_cin}, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].cin, 1'b0, lat, dones, s, c, s_end, cin_all, busy_load);
      check($sformatf("v%0d_sum", i), s, v[i].sum);
      check($sformatf("v%0d_cout", i), c, v[i].cout);
      check($sformatf("v%0d_latency", i), lat, 5);
      check($sformatf("v%0d_dones", i), dones, 1);
      check($sformatf("v%0d_stable", i), s_end, v[i].sum);
      check($sformatf("v%0d_load", i), busy_load, 1);
      if (i == 1) check("ripple_cin_all", cin_all, 1);
    end
    run_op(1'b0, 32'h01020304, 32'h10203040, 1'b0, 1'b1, lat, dones, s, c, s_end, cin_all, busy_load);
    check("poke_sum", s, 32'h11223344);
    check("poke_cout", c, 0);
    check("poke_latency", lat, 5);
    check("poke_dones", dones, 1);
    check("poke_idle", busy, 0);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'h12345678; b_in = 32'h00000001; c_in = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum_out, 0);
    check("mid_rst_cout", c_out, 0);
    check("mid_rst_adder", {add_a, add_b, add_cin}, 0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dones++; end
    check("mid_rst_no_done", dones, 0);
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, dones, s, c, s_end, cin_all, busy_load);
    check("post_rst_sum", s, 0);
    check("post_rst_cout", c, 1);
    check("post_rst_latency", lat, 5);
    @(negedge clk);
    start = 1'b1; op = 1'b0; c_in = 1'b0; a_in = ba[0]; b_in = bb[0];
    @(posedge clk); #1;
    a_in = ba[1]; b_in = bb[1];
    d = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 7) begin a_in = ba[2]; b_in = bb[2]; end
      if (cyc == 14) begin a_in = 32'hA5A5A5A5; b_in = 32'h5A5A5A5A; end
      if (cyc == 20) start = 1'b0;
      if (done) begin
        if (d < 3) begin
          check($sformatf("b2b%0d_at", d), cyc, 5 + 7*d);
          check($sformatf("b2b%0d_sum", d), sum_out, bs[d]);
          check($sformatf("b2b%0d_cout", d), c_out, bc[d]);
        end
        d++;
      end
    end
    check("b2b_count", d, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
